// File: rtl/chan_feed_6_if.sv
// rtl/chan_feed_6_if.sv - buffer read bus and six-channel beat stream of the partial-sum feeder
interface chan_feed_6_if #(
  parameter int DW = 16,
  parameter int AW = 10
);
  logic                 rd_en;
  logic [AW-1:0]        rd_addr;
  logic signed [DW-1:0] rd_data1, rd_data2, rd_data3, rd_data4, rd_data5, rd_data6;
  logic signed [DW-1:0] dout1, dout2, dout3, dout4, dout5, dout6;
  logic                 en1, en2, en3, en4, en5, en6;
  logic                 consume;

  modport master (
    output rd_en, rd_addr,
    input  rd_data1, rd_data2, rd_data3, rd_data4, rd_data5, rd_data6,
    output dout1, dout2, dout3, dout4, dout5, dout6,
    output en1, en2, en3, en4, en5, en6,
    input  consume
  );

  modport slave (
    input  rd_en, rd_addr,
    output rd_data1, rd_data2, rd_data3, rd_data4, rd_data5, rd_data6,
    input  dout1, dout2, dout3, dout4, dout5, dout6,
    input  en1, en2, en3, en4, en5, en6,
    output consume
  );
endinterface

// File: rtl/chan_feed_6.sv
// rtl/chan_feed_6.sv - credit-metered lockstep reader feeding six channel-adder FIFOs
module chan_feed_6 #(
  parameter int DW    = 16,
  parameter int AW    = 10,
  parameter int DEPTH = 16,
  parameter int NPIX  = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [5:0]    chan_mask,
  output logic          busy,
  output logic          done,
  output logic          err,
  chan_feed_6_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic [AW-1:0]       base_q, base_d;
  logic [5:0]          mask_q, mask_d;
  logic [CW-1:0]       outst_q, outst_d;
  logic                err_q, err_d;
  logic                emit_q;
  logic [5:0][DW-1:0]  hold_q;
  logic [5:0][DW-1:0]  rd_vec;
  logic [5:0][DW-1:0]  beat;
  logic [5:0][DW-1:0]  dout_vec;
  logic                issue;
  logic                last_issue;

  assign rd_vec = {bus.rd_data6, bus.rd_data5, bus.rd_data4,
                   bus.rd_data3, bus.rd_data2, bus.rd_data1};

  // An in-flight read already holds its credit, so a free slot is all that's needed.
  assign issue      = (state_q == S_RUN) && (outst_q < CW'(DEPTH));
  assign last_issue = issue && (idx_q == AW'(NPIX - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    mask_d  = mask_q;
    err_d   = err_q;
    outst_d = outst_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = base_addr;
          mask_d  = chan_mask;
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (issue) begin
          idx_d = idx_q + 1'b1;
          if (last_issue) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if ((outst_q == '0) && !emit_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A consume with nothing outstanding is a consumer bug; flag it after any start clear.
    if (issue && !bus.consume) begin
      outst_d = outst_q + 1'b1;
    end else if (!issue && bus.consume) begin
      if (outst_q != '0) begin
        outst_d = outst_q - 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_comb begin
    beat = '0;
    for (int n = 0; n < 6; n++) begin
      if (mask_q[n]) begin
        beat[n] = rd_vec[n];
      end
    end
    dout_vec = emit_q ? beat : hold_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      base_q  <= '0;
      mask_q  <= '0;
      outst_q <= '0;
      err_q   <= 1'b0;
      emit_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      mask_q  <= mask_d;
      outst_q <= outst_d;
      err_q   <= err_d;
      emit_q  <= issue;
      hold_q  <= dout_vec;
    end
  end

  // Read data arrives the cycle after rd_en, so the beat passes straight through then.
  assign bus.rd_en   = issue;
  assign bus.rd_addr = issue ? (base_q + idx_q) : '0;

  assign bus.dout1 = dout_vec[0];
  assign bus.dout2 = dout_vec[1];
  assign bus.dout3 = dout_vec[2];
  assign bus.dout4 = dout_vec[3];
  assign bus.dout5 = dout_vec[4];
  assign bus.dout6 = dout_vec[5];

  assign bus.en1 = emit_q;
  assign bus.en2 = emit_q;
  assign bus.en3 = emit_q;
  assign bus.en4 = emit_q;
  assign bus.en5 = emit_q;
  assign bus.en6 = emit_q;

  assign busy = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done = (state_q == S_DONE);
  assign err  = err_q;

endmodule
